// File: rtl/alu_exec_ctrl.sv
// Execute-stage sequencer: issues one decoded instruction to a single-cycle ALU op unit,
// captures its result and flags, owns the architectural N/Z/C register, and hands the result to writeback.
module alu_exec_ctrl #(
  parameter int N_OPS  = 8,
  parameter int OP_W   = 3,
  parameter int OP_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OP_W-1:0]      in_op,
  input  logic                 in_s,
  input  logic [3:0]           in_rd_idx,
  input  logic                 flush,
  output logic [N_OPS-1:0]     en_inst,
  input  logic [32*N_OPS-1:0]  op_rd,
  input  logic [3*N_OPS-1:0]   op_flags,
  output logic                 flag_n,
  output logic                 flag_z,
  output logic                 flag_c,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_rd,
  output logic [3:0]           out_rd_idx,
  output logic                 out_err
);

  localparam int CNT_W = $clog2(OP_LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [OP_W-1:0]  r_op;
  logic             r_s;
  logic [3:0]       r_rd_idx;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_rd;
  logic [3:0]       r_out_idx;
  logic             r_err;
  logic [2:0]       r_flags;

  logic             w_accept;
  logic             w_legal;
  logic             w_capture;
  logic [N_OPS-1:0] w_onehot;
  logic [31:0]      w_sel_rd;
  logic [2:0]       w_sel_flags;

  assign in_ready  = (r_state == S_IDLE) && !flush;
  assign w_accept  = in_valid && in_ready;
  assign w_legal   = int'(in_op) < N_OPS;
  assign w_capture = (r_state == S_ISSUE) && (r_cnt == '0) && !flush;

  // Decode of the latched op: one-hot enable plus the selected unit's result/flag slices.
  always_comb begin
    w_onehot    = '0;
    w_sel_rd    = '0;
    w_sel_flags = '0;
    for (int i = 0; i < N_OPS; i++) begin
      if (int'(r_op) == i) begin
        w_onehot[i] = 1'b1;
        w_sel_rd    = op_rd[32*i +: 32];
        w_sel_flags = op_flags[3*i +: 3];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = w_legal ? S_ISSUE : S_DONE;
      S_ISSUE: if (r_cnt == '0) w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
  end

  // Illegal ops skip the unit entirely and report an error result; flags only move on a clean capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op      <= '0;
      r_s       <= 1'b0;
      r_rd_idx  <= '0;
      r_cnt     <= '0;
      r_rd      <= '0;
      r_out_idx <= '0;
      r_err     <= 1'b0;
      r_flags   <= '0;
    end else begin
      if (w_accept) begin
        r_op     <= in_op;
        r_s      <= in_s;
        r_rd_idx <= in_rd_idx;
        r_cnt    <= CNT_W'(OP_LAT);
        if (!w_legal) begin
          r_rd      <= '0;
          r_out_idx <= in_rd_idx;
          r_err     <= 1'b1;
        end
      end
      if ((r_state == S_ISSUE) && !flush && (r_cnt != '0)) r_cnt <= r_cnt - 1'b1;
      if (w_capture) begin
        r_rd      <= w_sel_rd;
        r_out_idx <= r_rd_idx;
        r_err     <= 1'b0;
        if (r_s) r_flags <= w_sel_flags;
      end
    end
  end

  assign en_inst    = (r_state == S_ISSUE) ? w_onehot : '0;
  assign out_valid  = (r_state == S_DONE);
  assign out_rd     = r_rd;
  assign out_rd_idx = r_out_idx;
  assign out_err    = r_err;
  assign flag_n     = r_flags[2];
  assign flag_z     = r_flags[1];
  assign flag_c     = r_flags[0];

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Self-checking bench for alu_exec_ctrl: directed cases plus random instructions,
// results checked by a scoreboard monitor against a flag/result model kept here.
module tb_alu_exec_ctrl;

  localparam int N_OPS  = 6;
  localparam int OP_W   = 3;
  localparam int OP_LAT = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [OP_W-1:0]     in_op;
  logic                in_s;
  logic [3:0]          in_rd_idx;
  logic                flush;
  logic [N_OPS-1:0]    en_inst;
  logic [32*N_OPS-1:0] op_rd;
  logic [3*N_OPS-1:0]  op_flags;
  logic                flag_n, flag_z, flag_c;
  logic                out_valid;
  logic                out_ready;
  logic [31:0]         out_rd;
  logic [3:0]          out_rd_idx;
  logic                out_err;

  logic [31:0] unitRd [N_OPS];
  logic [2:0]  unitFl [N_OPS];

  typedef struct {
    logic [31:0] rd;
    logic [3:0]  idx;
    logic        err;
    logic [2:0]  fl;
  } exp_t;

  exp_t       sbQ[$];
  logic [2:0] mFlags;
  int         total = 0;
  int         bad = 0;

  alu_exec_ctrl #(.N_OPS(N_OPS), .OP_W(OP_W), .OP_LAT(OP_LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_s(in_s), .in_rd_idx(in_rd_idx), .flush(flush), .en_inst(en_inst),
    .op_rd(op_rd), .op_flags(op_flags), .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
    .out_rd_idx(out_rd_idx), .out_err(out_err)
  );

  always #5 clk = ~clk;

  always_comb begin
    op_rd    = '0;
    op_flags = '0;
    for (int i = 0; i < N_OPS; i++) begin
      op_rd[32*i +: 32] = unitRd[i];
      op_flags[3*i +: 3] = unitFl[i];
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every writeback handshake must match the oldest expected result.
  always @(negedge clk) begin
    if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sbQ.size() == 0) begin
        checkOutput("sb_unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = sbQ.pop_front();
        checkOutput("sb_rd", out_rd, e.rd);
        checkOutput("sb_rd_idx", out_rd_idx, e.idx);
        checkOutput("sb_err", out_err, e.err);
        checkOutput("sb_flags", {flag_n, flag_z, flag_c}, e.fl);
      end
    end
  end

  // Units need a fresh rising edge: at least two low cycles between enable pulses.
  int lowRun = 0;
  bit seenPulse = 0;
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      seenPulse = 0;
      lowRun = 0;
    end else if (en_inst == '0) begin
      lowRun++;
    end else begin
      if (seenPulse && lowRun > 0) checkOutput("en_low_gap_ge2", lowRun >= 2, 1);
      if (lowRun > 0) seenPulse = 1;
      lowRun = 0;
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  // Issue one instruction and follow it to its writeback handshake; entered/left at posedge+1.
  task automatic applyStimulus(input int op, input bit s, input logic [3:0] idx, input int stall,
                               input bit useFix, input logic [31:0] fixRd, input logic [2:0] fixFl);
    exp_t             e;
    bit               legal;
    int               k, enCnt;
    logic [N_OPS-1:0] expOh;
    logic [31:0]      held;
    for (int i = 0; i < N_OPS; i++) begin
      unitRd[i] = $urandom;
      unitFl[i] = 3'($urandom_range(0, 7));
    end
    legal = op < N_OPS;
    if (useFix && legal) begin
      unitRd[op] = fixRd;
      unitFl[op] = fixFl;
    end
    in_op     = OP_W'(op);
    in_s      = s;
    in_rd_idx = idx;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    @(negedge clk);
    checkOutput("in_ready_when_idle", in_ready, 1);
    if (legal) begin
      if (s) mFlags = unitFl[op];
      e = '{rd: unitRd[op], idx: idx, err: 1'b0, fl: mFlags};
      expOh = '0;
      expOh[op] = 1'b1;
    end else begin
      e = '{rd: 32'h0, idx: idx, err: 1'b1, fl: mFlags};
      expOh = '0;
    end
    sbQ.push_back(e);
    @(posedge clk); #1;
    in_valid = (stall > 0);
    k = 0;
    enCnt = 0;
    do begin
      @(negedge clk);
      k++;
      if (en_inst != '0) begin
        enCnt++;
        checkOutput("en_inst_onehot", en_inst, expOh);
      end
      checkOutput("in_ready_busy", in_ready, 0);
    end while (out_valid !== 1'b1 && k < 40);
    checkOutput("accept_to_valid", k, legal ? OP_LAT + 2 : 1);
    checkOutput("en_high_cycles", enCnt, legal ? OP_LAT + 1 : 0);
    held = out_rd;
    for (int j = 0; j < stall; j++) begin
      @(posedge clk); #1;
      if (j == stall - 1) begin
        out_ready = 1'b1;
        in_valid  = 1'b0;
      end
      @(negedge clk);
      checkOutput("stall_out_valid", out_valid, 1);
      checkOutput("stall_out_rd", out_rd, held);
      checkOutput("stall_en_inst", en_inst, 0);
      checkOutput("stall_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Cancel an in-flight instruction either exactly on its capture edge or while its result waits.
  task automatic flushCase(input bit onCapture, input int op);
    for (int i = 0; i < N_OPS; i++) unitFl[i] = 3'b110;
    unitRd[0] = $urandom;
    in_op     = OP_W'(op);
    in_s      = 1'b1;
    in_rd_idx = 4'hA;
    in_valid  = 1'b1;
    out_ready = !onCapture ? 1'b0 : 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (onCapture) begin
      repeat (OP_LAT) @(posedge clk);
      #1;
    end else begin
      @(negedge clk);
      checkOutput("flush_done_pending", out_valid, 1);
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      checkOutput("flush_no_valid", out_valid, 0);
      checkOutput("flush_en_low", en_inst, 0);
      checkOutput("flush_flags_kept", {flag_n, flag_z, flag_c}, mFlags);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 1'b0; in_op = '0; in_s = 1'b0; in_rd_idx = '0; flush = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < N_OPS; i++) begin
      unitRd[i] = '0;
      unitFl[i] = '0;
    end
    mFlags = 3'b000;
    #1;
    checkOutput("rst_en_inst", en_inst, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_flags", {flag_n, flag_z, flag_c}, 0);
    checkOutput("rst_out_rd", out_rd, 0);
    checkOutput("rst_out_rd_idx", out_rd_idx, 0);
    checkOutput("rst_out_err", out_err, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    applyStimulus(2, 1'b1, 4'd5, 0, 1'b1, 32'h0000F0F0, 3'b001);
    applyStimulus(1, 1'b1, 4'd3, 0, 1'b1, 32'h12345678, 3'b000);
    applyStimulus(3, 1'b0, 4'd7, 0, 1'b1, 32'hDEADBEEF, 3'b111);
    applyStimulus(4, 1'b1, 4'd9, 5, 1'b0, 32'h0, 3'b0);
    applyStimulus(7, 1'b1, 4'd2, 0, 1'b0, 32'h0, 3'b0);
    applyStimulus(6, 1'b1, 4'd1, 2, 1'b0, 32'h0, 3'b0);
    applyStimulus(0, 1'b1, 4'd4, 0, 1'b1, 32'h00000001, 3'b001);
    flushCase(1'b1, 5);
    applyStimulus(5, 1'b1, 4'd6, 0, 1'b1, 32'hCAFEF00D, 3'b100);
    flushCase(1'b0, 7);

    for (int n = 0; n < 40; n++) begin
      applyStimulus($urandom_range(0, 7), 1'($urandom), 4'($urandom), $urandom_range(0, 3),
                    1'b0, 32'h0, 3'b0);
    end

    applyStimulus(0, 1'b1, 4'd8, 0, 1'b1, 32'hFFFFFFFF, 3'b111);
    in_op = OP_W'(1); in_s = 1'b1; in_rd_idx = 4'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    mFlags = 3'b000;
    checkOutput("midrst_en_inst", en_inst, 0);
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_flags", {flag_n, flag_z, flag_c}, 0);
    checkOutput("midrst_out_rd", out_rd, 0);
    @(posedge clk); #3;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("postrst_in_ready", in_ready, 1);
    checkOutput("postrst_en_inst", en_inst, 0);
    @(posedge clk); #1;
    applyStimulus(3, 1'b1, 4'd12, 1, 1'b1, 32'h0BADC0DE, 3'b010);

    repeat (3) @(posedge clk);
    checkOutput("sb_drained", sbQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
